// File: rtl/tr_pkg.sv
// Shared state encoding and default 50 MHz timing for the step sequencer.
package tr_pkg;

  localparam int DEF_WIDTH_WORK = 16;
  localparam int DEF_PULSE_W    = 100;
  localparam int DEF_DIR_SETUP  = 250;
  localparam int DEF_EN_DELAY   = 500;
  localparam int DEF_MIN_PERIOD = 2 * DEF_PULSE_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAKE     = 3'd1,
    ST_BOUNDARY = 3'd2,
    ST_SETUP    = 3'd3,
    ST_HIGH     = 3'd4,
    ST_LOW      = 3'd5
  } step_state_e;

  // Zero means hold and passes through; any other value is raised to the floor.
  function automatic int unsigned clamp_period(input int unsigned p, input int unsigned floor_p);
    return ((p != 32'd0) && (p < floor_p)) ? floor_p : p;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module tick_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] cnt_r;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= value;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);

endmodule

// File: rtl/step_sequencer.sv
// Turns a period command into stepper driver timing (enable wake, dir setup, pulse, period)
// and tracks a signed position count of issued steps.
module step_sequencer
  import tr_pkg::*;
#(
  parameter int WIDTH_WORK = DEF_WIDTH_WORK,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int DIR_SETUP  = DEF_DIR_SETUP,
  parameter int EN_DELAY   = DEF_EN_DELAY,
  parameter int MIN_PERIOD = 2 * PULSE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  dir_in,
  input  logic [WIDTH_WORK-1:0] period,
  input  logic                  period_valid,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  drv_enable,
  output logic                  busy,
  output logic [WIDTH_WORK-1:0] position
);

  // A state loaded with N lasts N+1 cycles, so each load is one short of its dwell,
  // except WAKE which deliberately includes the enable edge cycle.
  localparam logic [WIDTH_WORK-1:0] ONE        = {{(WIDTH_WORK-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_WORK-1:0] WAKE_LOAD  = WIDTH_WORK'(EN_DELAY);
  localparam logic [WIDTH_WORK-1:0] SETUP_LOAD = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] HIGH_LOAD  = WIDTH_WORK'(PULSE_W - 1);
  localparam logic [WIDTH_WORK-1:0] LOW_TRIM   = WIDTH_WORK'(PULSE_W + 2);

  step_state_e           state_r, state_s;
  logic [WIDTH_WORK-1:0] latch_r, step_period_r, position_r;
  logic [WIDTH_WORK-1:0] eff_period_s, sampled_s, cnt_value_s;
  logic                  cnt_load_s, cnt_done_s, sample_s, dir_change_s;
  logic                  drv_step_r, drv_dir_r, drv_enable_r, busy_r;

  // A strobe coinciding with the boundary decision wins over the stored latch.
  assign eff_period_s = period_valid ? period : latch_r;
  assign sampled_s    = WIDTH_WORK'(clamp_period(32'(eff_period_s), 32'(MIN_PERIOD)));

  tick_counter #(.WIDTH(WIDTH_WORK)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load_s),
    .value (cnt_value_s),
    .done  (cnt_done_s)
  );

  // Next-state, counter load and boundary decisions.
  always_comb begin
    state_s      = state_r;
    cnt_load_s   = 1'b0;
    cnt_value_s  = '0;
    sample_s     = 1'b0;
    dir_change_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_s     = ST_WAKE;
          cnt_load_s  = 1'b1;
          cnt_value_s = WAKE_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAKE, ST_SETUP: begin
        if (!run)            state_s = ST_IDLE;
        else if (cnt_done_s) state_s = ST_BOUNDARY;
        else                 state_s = state_r;
      end
      ST_BOUNDARY: begin
        if (!run) begin
          state_s = ST_IDLE;
        end else if (dir_in != drv_dir_r) begin
          state_s      = ST_SETUP;
          dir_change_s = 1'b1;
          cnt_load_s   = 1'b1;
          cnt_value_s  = SETUP_LOAD;
        end else if (eff_period_s == '0) begin
          state_s = ST_BOUNDARY;
        end else begin
          state_s     = ST_HIGH;
          sample_s    = 1'b1;
          cnt_load_s  = 1'b1;
          cnt_value_s = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        // The pulse always completes; a dropped run is honoured at its end.
        if (cnt_done_s) begin
          if (run) begin
            state_s     = ST_LOW;
            cnt_load_s  = 1'b1;
            cnt_value_s = step_period_r - LOW_TRIM;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (!run)            state_s = ST_IDLE;
        else if (cnt_done_s) state_s = ST_BOUNDARY;
        else                 state_s = ST_LOW;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, period latches and registered driver outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      latch_r       <= '0;
      step_period_r <= '0;
      drv_step_r    <= 1'b0;
      drv_dir_r     <= 1'b0;
      drv_enable_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      latch_r       <= period_valid ? period : latch_r;
      step_period_r <= sample_s ? sampled_s : step_period_r;
      drv_step_r    <= (state_s == ST_HIGH);
      drv_enable_r  <= (state_s != ST_IDLE);
      busy_r        <= (state_s != ST_IDLE);
      if (state_s == ST_IDLE) begin
        drv_dir_r <= 1'b0;
      end else if ((state_r == ST_IDLE) || dir_change_s) begin
        drv_dir_r <= dir_in;
      end else begin
        drv_dir_r <= drv_dir_r;
      end
    end
  end

  // Position moves on the edge the step pulse rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position_r <= '0;
    end else if (sample_s) begin
      position_r <= drv_dir_r ? (position_r + ONE) : (position_r - ONE);
    end else begin
      position_r <= position_r;
    end
  end

  assign drv_step   = drv_step_r;
  assign drv_dir    = drv_dir_r;
  assign drv_enable = drv_enable_r;
  assign busy       = busy_r;
  assign position   = position_r;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed + randomized bench for step_sequencer against a timestamp-based reference model.
module tb_step_sequencer;

  localparam int W  = 16;
  localparam int PW = 4;
  localparam int DS = 6;
  localparam int ED = 3;
  localparam int MP = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         run = 1'b0;
  logic         dir_in = 1'b0;
  logic [W-1:0] period = '0;
  logic         period_valid = 1'b0;
  logic         drv_step, drv_dir, drv_enable, busy;
  logic [W-1:0] position;

  step_sequencer #(
    .WIDTH_WORK (W),
    .PULSE_W    (PW),
    .DIR_SETUP  (DS),
    .EN_DELAY   (ED),
    .MIN_PERIOD (MP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .dir_in       (dir_in),
    .period       (period),
    .period_valid (period_valid),
    .drv_step     (drv_step),
    .drv_dir      (drv_dir),
    .drv_enable   (drv_enable),
    .busy         (busy),
    .position     (position)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the driver is described by timestamps (edge of the next
  // boundary decision, edge of the last rise) rather than by state counters.
  int           m_k = 0;
  bit           m_en, m_dir;
  logic [W-1:0] m_pos, m_latch;
  int           m_dec, m_rise;

  function automatic int clampp(input int p);
    return (p != 0 && p < MP) ? MP : p;
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_dir = 1'b0; m_pos = '0; m_latch = '0; m_dec = 0; m_rise = -1000;
  endtask

  task automatic model_idle();
    m_en = 1'b0; m_dir = 1'b0; m_rise = -1000;
  endtask

  task automatic model_step();
    int eff;
    m_k++;
    eff = period_valid ? int'(period) : int'(m_latch);
    if (!m_en) begin
      if (run) begin
        m_en = 1'b1; m_dir = dir_in; m_dec = m_k + ED + 2;
      end
    end else if (m_k == m_dec) begin
      if (!run) model_idle();
      else if (dir_in != m_dir) begin
        m_dir = dir_in; m_dec = m_k + DS + 1;
      end else if (eff == 0) m_dec = m_k + 1;
      else begin
        m_rise = m_k;
        m_pos  = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
        m_dec  = m_k + clampp(eff);
      end
    end else if (!run && !(m_k > m_rise && m_k < m_rise + PW)) begin
      model_idle();
    end
    if (period_valid) m_latch = period;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare plus an edge monitor used by the directed literal checks.
  int cyc = 0;
  int rise_q[$];
  int fall_q[$];
  int en_rise_t = -1, en_fall_t = -1, dir_t = -1;

  initial begin
    logic p_step, p_en, p_dir, e_step;
    p_step = 1'b0; p_en = 1'b0; p_dir = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      e_step = m_en && (m_k >= m_rise) && (m_k < m_rise + PW);
      chk("drv_step", 32'(drv_step), 32'(e_step));
      chk("drv_dir", 32'(drv_dir), 32'(m_dir));
      chk("drv_enable", 32'(drv_enable), 32'(m_en));
      chk("busy", 32'(busy), 32'(m_en));
      chk("position", 32'(position), 32'(m_pos));
      if (drv_step && !p_step) rise_q.push_back(cyc);
      if (!drv_step && p_step) fall_q.push_back(cyc);
      if (drv_enable && !p_en) en_rise_t = cyc;
      if (!drv_enable && p_en) en_fall_t = cyc;
      if (drv_dir != p_dir) dir_t = cyc;
      p_step = drv_step; p_en = drv_enable; p_dir = drv_dir;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_rises(input int target, input int budget);
    for (int i = 0; i < budget && rise_q.size() < target; i++) tick(1);
    chk("wait_rise_timeout", 32'(rise_q.size() >= target), 32'd1);
  endtask

  task automatic strobe(input int p);
    period = W'(p); period_valid = 1'b1;
    tick(1);
    period_valid = 1'b0;
  endtask

  initial begin
    int nb;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1: period 20, forward
    period = 16'd20; period_valid = 1'b1; run = 1'b1; dir_in = 1'b1;
    tick(1);
    period_valid = 1'b0;
    wait_rises(2, 60);
    chk("first_rise_delay", 32'(rise_q[0] - en_rise_t), 32'd5);
    chk("spacing_20", 32'(rise_q[1] - rise_q[0]), 32'd20);
    chk("high_width", 32'(fall_q[0] - rise_q[0]), 32'd4);
    chk("pos_after_2", 32'(position), 32'd2);

    // 2: new period mid-LOW only affects the following step
    tick(8);
    strobe(30);
    wait_rises(4, 80);
    chk("spacing_kept_20", 32'(rise_q[2] - rise_q[1]), 32'd20);
    chk("spacing_30", 32'(rise_q[3] - rise_q[2]), 32'd30);

    // 3: reverse during HIGH
    dir_in = 1'b0;
    wait_rises(5, 80);
    chk("dir_setup_gap", 32'(rise_q[4] - dir_t), 32'd7);
    chk("spacing_dirchg", 32'(rise_q[4] - rise_q[3]), 32'd37);
    chk("dir_after_pulse", 32'(dir_t > fall_q[3]), 32'd1);
    chk("pos_dec", 32'(position), 32'd3);

    // 4: clamp, hold, resume
    strobe(3);
    wait_rises(7, 80);
    chk("spacing_clamped", 32'(rise_q[6] - rise_q[5]), 32'd8);
    strobe(0);
    nb = rise_q.size();
    tick(40);
    chk("hold_no_rise", 32'(rise_q.size()), 32'(nb));
    chk("pos_at_hold", 32'(position), 32'd1);
    strobe(15);
    wait_rises(nb + 2, 60);
    chk("spacing_15", 32'(rise_q[nb+1] - rise_q[nb]), 32'd15);

    // 5: drop run during HIGH
    run = 1'b0;
    tick(10);
    chk("last_high_width", 32'(fall_q[$] - rise_q[$]), 32'd4);
    chk("en_fall_with_step", 32'(en_fall_t), 32'(fall_q[$]));
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("pos_retained", 32'(position), 32'hFFFF);

    // 6: async reset mid-HIGH at position 5
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run = 1'b1; dir_in = 1'b1;
    strobe(8);
    nb = rise_q.size();
    wait_rises(nb + 5, 100);
    chk("pos_5", 32'(position), 32'd5);
    chk("step_high_pre_rst", 32'(drv_step), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_step", 32'(drv_step), 32'd0);
    chk("rst_enable", 32'(drv_enable), 32'd0);
    chk("rst_dir", 32'(drv_dir), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_position", 32'(position), 32'd0);
    run = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("idle_after_rst", 32'(drv_enable), 32'd0);

    // Randomized phase, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      period_valid = 1'b0;
      if (run ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 7) == 0)) run = ~run;
      if ($urandom_range(0, 39) == 0) dir_in = ~dir_in;
      if ($urandom_range(0, 15) == 0) begin
        period_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       period = '0;
          1:       period = W'($urandom_range(1, 10));
          2:       period = W'($urandom_range(8, 40));
          default: period = W'($urandom_range(41, 90));
        endcase
      end
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Converts the tracking loop's pulse-period command into a stepper-motor drive waveform. Sits between the tracking-mode controller (source of the period word `N`, its strobe, the direction and the motor-enable request) and the motor driver pins. Owns all driver timing: enable wake-up, direction setup, minimum pulse width and step period. Also keeps a signed position count of issued steps.

## Interface

- `WIDTH_WORK`, 16: width of the period word and the position counter.
- `PULSE_W`, 100: `drv_step` high time in clocks (2 µs at 50 MHz).
- `DIR_SETUP`, 250: clocks between a `drv_dir` change and the next step rising edge.
- `EN_DELAY`, 500: clocks from `drv_enable` rising to the first possible step.
- `MIN_PERIOD`, 2*`PULSE_W`: lower clamp on the step period.

Ports:

- `clk`, in, 1: 50 MHz system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: motor enable request from the tracking controller.
- `dir_in`, in, 1: requested direction.
- `period`, in, `WIDTH_WORK`: clocks per step. 0 means hold.
- `period_valid`, in, 1: one-cycle strobe, synchronous to `clk`. Latches `period`.
- `drv_step`, out, 1: step pulse, registered.
- `drv_dir`, out, 1: direction to the driver, registered.
- `drv_enable`, out, 1: driver enable, registered.
- `busy`, out, 1: high in any state other than IDLE.
- `position`, out, `WIDTH_WORK`: signed step count, two's complement, wraps.

## Operation

- Reset values:
  - `drv_step`=0, `drv_dir`=0, `drv_enable`=0, `busy`=0, `position`=0.
  - Period latch = 0.
  - State = IDLE.
- Period latch:
  - Loads `period` on `period_valid` in any state, including IDLE.
  - The active step uses a separate copy, sampled only at a step boundary. A step in progress is never stretched or shortened.
  - A sampled nonzero value below `MIN_PERIOD` is clamped to `MIN_PERIOD`.
- IDLE:
  - Outputs low.
  - If `run`=1: go to WAKE, set `drv_enable`=1, load `drv_dir`<=`dir_in`.
- WAKE:
  - Count `EN_DELAY` clocks, then go to BOUNDARY.
  - If `run` drops: go to IDLE.
- BOUNDARY (a one-cycle decision state):
  - If `run`=0: go to IDLE.
  - Else if `dir_in`≠`drv_dir`: update `drv_dir`, go to SETUP.
  - Else if latched period = 0: stay in BOUNDARY, re-evaluating every cycle (hold).
  - Else: sample the period, go to HIGH.
- SETUP:
  - Count `DIR_SETUP` clocks, then go to BOUNDARY.
  - If `run` drops: go to IDLE.
- HIGH:
  - `drv_step`=1 for `PULSE_W` clocks, then go to LOW.
  - On entry, `position` += 1 if `drv_dir`=1, else −1.
  - `run` dropping does not truncate the pulse.
- LOW:
  - `drv_step`=0 for (sampled period − `PULSE_W` − 1) clocks, then go to BOUNDARY.
  - If `run` drops: go to IDLE immediately.
- Leaving to IDLE from any state clears `drv_enable` and `drv_step` on the same edge the state becomes IDLE. `position` is retained.
- Simultaneous events:
  - `period_valid` in the same cycle BOUNDARY samples: the new value is used.
  - A `dir_in` change during HIGH/LOW takes effect at the next BOUNDARY.

## Timing

- `run` sampled high at edge t: `drv_enable`=1 after t.
- First `drv_step` rise: EN_DELAY+2 cycles after `drv_enable` rises, when `dir_in` is stable.
- Rising-edge to rising-edge spacing equals the sampled period P (LOW + BOUNDARY accounts for P−`PULSE_W`).
- Direction change adds `DIR_SETUP`+1 cycles before the next rise. `drv_dir` never changes while `drv_step`=1.
- `position` updates on the same edge `drv_step` rises.
- Reset assertion is asynchronous mid-pulse: all outputs go to reset values at once. Release is synchronous to the next `clk` edge.

## Structure

- Shared package `tr_pkg`:
  - State enum (IDLE, WAKE, BOUNDARY, SETUP, HIGH, LOW).
  - `WIDTH_WORK` default.
  - Default timing constants for 50 MHz.
- One natural sub-module, `tick_counter`: a loadable down-counter with a `done` output. Reused for WAKE, SETUP, HIGH and LOW.

## Test plan

Test parameters: `PULSE_W`=4, `DIR_SETUP`=6, `EN_DELAY`=3, `MIN_PERIOD`=8.

1. Period strobe 20, `run`=1, `dir_in`=1 → `drv_enable` next cycle, first step rise 5 cycles later, rises every 20 cycles, high 4 cycles each, `position` 1,2,3…
2. While stepping at 20, strobe period 30 mid-LOW → current spacing stays 20, following spacing 30.
3. Toggle `dir_in` to 0 during HIGH → `drv_dir` changes only after the pulse ends, next rise ≥7 cycles after the `drv_dir` edge, `position` decrements.
4. Strobe period 3 → spacing 8 (clamped). Strobe 0 → no further rises. Strobe 15 → steps resume at spacing 15.
5. Drop `run` during HIGH → pulse completes its 4 cycles, then `drv_enable`=0, `busy`=0, `position` retained.
6. Assert `rst_n`=0 mid-HIGH with `position`=5 → all outputs 0 asynchronously. After release with `run`=0, the block stays in IDLE.
